// File: rtl/calc_input_sequencer_pkg.sv
// Shared definitions for the calculator input sequencer: keypad command
// codes, ALU operator codes, FSM state encoding and command decode helpers.
package calc_input_sequencer_pkg;

  localparam int IC_N = 5;
  localparam int OP_N = 3;

  // Keypad encoder command codes; digits are contiguous so the digit value
  // is the code minus IC_NUM0.
  localparam logic [IC_N-1:0] IC_NONE = 5'd0;
  localparam logic [IC_N-1:0] IC_NUM0 = 5'd1;
  localparam logic [IC_N-1:0] IC_NUM1 = 5'd2;
  localparam logic [IC_N-1:0] IC_NUM2 = 5'd3;
  localparam logic [IC_N-1:0] IC_NUM3 = 5'd4;
  localparam logic [IC_N-1:0] IC_NUM4 = 5'd5;
  localparam logic [IC_N-1:0] IC_NUM5 = 5'd6;
  localparam logic [IC_N-1:0] IC_NUM6 = 5'd7;
  localparam logic [IC_N-1:0] IC_NUM7 = 5'd8;
  localparam logic [IC_N-1:0] IC_NUM8 = 5'd9;
  localparam logic [IC_N-1:0] IC_NUM9 = 5'd10;
  localparam logic [IC_N-1:0] IC_OPAD = 5'd11;
  localparam logic [IC_N-1:0] IC_OPSB = 5'd12;
  localparam logic [IC_N-1:0] IC_OPAN = 5'd13;
  localparam logic [IC_N-1:0] IC_OPOR = 5'd14;
  localparam logic [IC_N-1:0] IC_OPLS = 5'd15;
  localparam logic [IC_N-1:0] IC_CTOK = 5'd16;

  // ALU operator codes.
  localparam logic [OP_N-1:0] OP_ADD = 3'd0;
  localparam logic [OP_N-1:0] OP_SUB = 3'd1;
  localparam logic [OP_N-1:0] OP_AND = 3'd2;
  localparam logic [OP_N-1:0] OP_OR  = 3'd3;
  localparam logic [OP_N-1:0] OP_LS  = 3'd4;

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_OP    = 3'd1,
    S_B     = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_RES   = 3'd5
  } state_t;

  function automatic logic ic_is_digit(input logic [IC_N-1:0] c);
    return (c >= IC_NUM0) && (c <= IC_NUM9);
  endfunction

  function automatic logic ic_is_op(input logic [IC_N-1:0] c);
    return (c >= IC_OPAD) && (c <= IC_OPLS);
  endfunction

  function automatic logic [3:0] ic_digit(input logic [IC_N-1:0] c);
    logic [IC_N-1:0] t;
    t = c - IC_NUM0;
    return t[3:0];
  endfunction

  function automatic logic [OP_N-1:0] ic_to_op(input logic [IC_N-1:0] c);
    logic [OP_N-1:0] o;
    case (c)
      IC_OPSB: o = OP_SUB;
      IC_OPAN: o = OP_AND;
      IC_OPOR: o = OP_OR;
      IC_OPLS: o = OP_LS;
      default: o = OP_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/calc_input_sequencer_digit_acc.sv
// calc_digit_acc: decimal digit accumulator step, acc*10 + d, computed in
// W+4 bits so a result above 2^W-1 is detected and the digit dropped.
module calc_digit_acc #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   d,
  output logic [W-1:0] next,
  output logic         ovf
);

  logic [W+3:0] wide_acc;
  logic [W+3:0] sum;

  // acc*10 as (acc<<3)+(acc<<1); on overflow the accumulator is held.
  always_comb begin
    wide_acc = {4'b0000, acc};
    sum      = (wide_acc << 3) + (wide_acc << 1) + {{W{1'b0}}, d};
    ovf      = |sum[W+3:W];
    next     = ovf ? acc : sum[W-1:0];
  end

endmodule

// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer: turns keypad commands into one ALU operation per
// CTOK, holds the returned result and drives the display value.
// Optional feature macro: CALC_CHAIN_EN (operator after a result chains it
// as the next operand A).
//
// Handshake: exec_valid rises with exec_a/exec_b/exec_op stable and they
// stay unchanged until the rising edge where exec_ready is sampled high;
// that edge is the transfer and exec_valid drops the following cycle.
// Reset is the only way to withdraw a pending request.
module calc_input_sequencer
  import calc_input_sequencer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [IC_N-1:0] cmd,
  output logic            exec_valid,
  input  logic            exec_ready,
  output logic [W-1:0]    exec_a,
  output logic [W-1:0]    exec_b,
  output logic [OP_N-1:0] exec_op,
  input  logic            res_valid,
  input  logic [W-1:0]    res_data,
  output logic [W-1:0]    disp_value,
  output logic            ovf,
  output logic            busy,
  output state_t          dbg_state
);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, r_q, r_d, disp_q, disp_d;
  logic [OP_N-1:0] op_q, op_d;
  logic            ovf_q, ovf_d, valid_q, valid_d, busy_q, busy_d;

  logic            is_dig, is_op;
  logic [3:0]      dig;
  logic [W-1:0]    dig_w, acc_in, acc_next;
  logic            acc_ovf;

  // One shared accumulator, fed with B while entering B, otherwise A.
  assign acc_in = (state_q == S_B) ? b_q : a_q;

  calc_digit_acc #(.W(W)) u_acc (
    .acc  (acc_in),
    .d    (dig),
    .next (acc_next),
    .ovf  (acc_ovf)
  );

  // Next-state, operand and registered-output computation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    is_dig  = ic_is_digit(cmd);
    is_op   = ic_is_op(cmd);
    dig     = ic_digit(cmd);
    dig_w   = {{(W-4){1'b0}}, dig};

    case (state_q)
      S_A: begin
        if (is_dig) begin
          a_d = acc_next;
          if (acc_ovf) ovf_d = 1'b1;
        end else if (is_op) begin
          op_d    = ic_to_op(cmd);
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (is_dig) begin
          b_d     = dig_w;
          ovf_d   = 1'b0;
          state_d = S_B;
        end else if (is_op) begin
          op_d = ic_to_op(cmd);
        end
      end
      S_B: begin
        if (is_dig) begin
          b_d = acc_next;
          if (acc_ovf) ovf_d = 1'b1;
        end else if (cmd == IC_CTOK) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (exec_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) begin
          r_d     = res_data;
          state_d = S_RES;
        end
      end
      S_RES: begin
        if (is_dig) begin
          a_d     = dig_w;
          ovf_d   = 1'b0;
          state_d = S_A;
        end
`ifdef CALC_CHAIN_EN
        else if (is_op) begin
          a_d     = r_q;
          op_d    = ic_to_op(cmd);
          state_d = S_OP;
        end
`endif
      end
      default: state_d = S_A;
    endcase

    valid_d = (state_d == S_ISSUE);
    busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT);
    case (state_d)
      S_A, S_OP:               disp_d = a_d;
      S_B, S_ISSUE, S_WAIT:    disp_d = b_d;
      S_RES:                   disp_d = r_d;
      default:                 disp_d = '0;
    endcase
  end

  // FSM state, operands and registered outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= OP_ADD;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      disp_q  <= disp_d;
    end
  end

  assign exec_valid = valid_q;
  assign exec_a     = a_q;
  assign exec_b     = b_q;
  assign exec_op    = op_q;
  assign disp_value = disp_q;
  assign ovf        = ovf_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed bench for calc_input_sequencer: scoreboard of expected ALU
// requests checked by a monitor at each transfer, plus direct checks of the
// display, overflow flag, busy and state after each press.
module tb_calc_input_sequencer;
  import calc_input_sequencer_pkg::*;

  localparam int W  = 16;
  localparam int XW = 2*W + OP_N;

  logic            Clock;
  logic            Reset;
  logic [IC_N-1:0] cmd;
  logic            exec_valid;
  logic            exec_ready;
  logic [W-1:0]    exec_a;
  logic [W-1:0]    exec_b;
  logic [OP_N-1:0] exec_op;
  logic            res_valid;
  logic [W-1:0]    res_data;
  logic [W-1:0]    disp_value;
  logic            ovf;
  logic            busy;
  state_t          dbg_state;

  int total = 0;
  int bad   = 0;
  logic [XW-1:0] exp_q[$];

  calc_input_sequencer #(.W(W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .cmd        (cmd),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .exec_a     (exec_a),
    .exec_b     (exec_b),
    .exec_op    (exec_op),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .disp_value (disp_value),
    .ovf        (ovf),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic press(input logic [IC_N-1:0] c);
    cmd = c;
    tick();
    cmd = IC_NONE;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic give_result(input logic [W-1:0] v);
    res_valid = 1'b1;
    res_data  = v;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OP_N-1:0] op);
    exp_q.push_back({a, b, op});
  endtask

  // Monitor: every accepted request is popped against the scoreboard.
  always @(negedge Clock) begin : mon
    logic [XW-1:0] e;
    if (Reset && exec_valid && exec_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL exec_unexpected got a=%0d b=%0d op=%0d expected none", exec_a, exec_b, exec_op);
      end else begin
        e = exp_q.pop_front();
        if ({exec_a, exec_b, exec_op} !== e) begin
          bad++;
          $display("FAIL exec_xfer got a=%0d b=%0d op=%0d expected a=%0d b=%0d op=%0d",
                   exec_a, exec_b, exec_op, e[XW-1:W+OP_N], e[W+OP_N-1:OP_N], e[OP_N-1:0]);
        end
      end
    end
  end

  initial begin
    Reset      = 1'b0;
    cmd        = IC_NONE;
    exec_ready = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    tick();
    tick();

    // Reset values
    check("rst_valid", 32'(exec_valid), 32'd0);
    check("rst_disp", 32'(disp_value), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_A));
    check("rst_op", 32'(exec_op), 32'(OP_ADD));
    Reset = 1'b1;

    // 12 + 3 with exec_ready held high
    exec_ready = 1'b1;
    press(IC_NUM1);  check("t1_disp_1", 32'(disp_value), 32'd1);
    press(IC_NUM2);  check("t1_disp_12", 32'(disp_value), 32'd12);
    press(IC_OPAD);  check("t1_state_op", 32'(dbg_state), 32'(S_OP));
    check("t1_disp_op", 32'(disp_value), 32'd12);
    press(IC_NUM3);  check("t1_disp_3", 32'(disp_value), 32'd3);
    push_exp(16'd12, 16'd3, OP_ADD);
    press(IC_CTOK);
    check("t1_valid_hi", 32'(exec_valid), 32'd1);
    check("t1_busy_hi", 32'(busy), 32'd1);
    tick();
    check("t1_valid_1cyc", 32'(exec_valid), 32'd0);
    check("t1_state_wait", 32'(dbg_state), 32'(S_WAIT));
    check("t1_disp_wait", 32'(disp_value), 32'd3);
    give_result(16'd15);
    check("t1_disp_res", 32'(disp_value), 32'd15);
    check("t1_state_res", 32'(dbg_state), 32'(S_RES));
    check("t1_busy_lo", 32'(busy), 32'd0);

    // Operator after a held result
    press(IC_OPLS);
`ifdef CALC_CHAIN_EN
    check("ch_state_op", 32'(dbg_state), 32'(S_OP));
    check("ch_disp_a", 32'(disp_value), 32'd15);
    press(IC_NUM2);
    push_exp(16'd15, 16'd2, OP_LS);
    press(IC_CTOK);
    check("ch_valid", 32'(exec_valid), 32'd1);
    tick();
    give_result(16'd60);
    check("ch_disp_res", 32'(disp_value), 32'd60);
`else
    check("nc_state_res", 32'(dbg_state), 32'(S_RES));
    check("nc_disp_r", 32'(disp_value), 32'd15);
    press(IC_NUM2);
    check("nc_state_a", 32'(dbg_state), 32'(S_A));
    check("nc_disp_a", 32'(disp_value), 32'd2);
    press(IC_CTOK);
    check("nc_ctok_ign", 32'(exec_valid), 32'd0);
`endif

    // Stall: exec_ready low for 5 cycles, NUM7 pressed meanwhile
    do_reset();
    exec_ready = 1'b0;
    press(IC_NUM9);
    press(IC_OPOR);
    press(IC_NUM6);
    push_exp(16'd9, 16'd6, OP_OR);
    press(IC_CTOK);
    for (int i = 0; i < 5; i++) begin
      check("st_valid", 32'(exec_valid), 32'd1);
      check("st_a", 32'(exec_a), 32'd9);
      check("st_b", 32'(exec_b), 32'd6);
      check("st_op", 32'(exec_op), 32'(OP_OR));
      if (i == 2) press(IC_NUM7);
      else tick();
    end
    exec_ready = 1'b1;
    check("st_valid_ready", 32'(exec_valid), 32'd1);
    tick();
    check("st_valid_drop", 32'(exec_valid), 32'd0);
    check("st_disp_b", 32'(disp_value), 32'd6);
    give_result(16'd15);
    check("st_disp_res", 32'(disp_value), 32'd15);

    // Digit overflow at W=16
    do_reset();
    press(IC_NUM6);
    press(IC_NUM5);
    press(IC_NUM5);
    press(IC_NUM3);
    check("ov_6553", 32'(disp_value), 32'd6553);
    press(IC_NUM5);
    check("ov_65535", 32'(disp_value), 32'd65535);
    check("ov_flag_lo", 32'(ovf), 32'd0);
    press(IC_NUM9);
    check("ov_hold", 32'(disp_value), 32'd65535);
    check("ov_flag_hi", 32'(ovf), 32'd1);
    press(IC_OPAD);
    check("ov_flag_keep", 32'(ovf), 32'd1);
    press(IC_NUM1);
    check("ov_flag_clr", 32'(ovf), 32'd0);
    check("ov_disp_b", 32'(disp_value), 32'd1);
    push_exp(16'd65535, 16'd1, OP_ADD);
    press(IC_CTOK);
    tick();
    give_result(16'd0);
    check("ov_disp_res", 32'(disp_value), 32'd0);

    // Operator replacement, CTOK ignored in S_A and S_OP
    do_reset();
    press(IC_NUM4);
    press(IC_CTOK);
    check("rp_ctok_a_valid", 32'(exec_valid), 32'd0);
    check("rp_ctok_a_state", 32'(dbg_state), 32'(S_A));
    press(IC_OPAD);
    press(IC_CTOK);
    check("rp_ctok_op_valid", 32'(exec_valid), 32'd0);
    check("rp_ctok_op_state", 32'(dbg_state), 32'(S_OP));
    press(IC_OPSB);
    press(IC_NUM1);
    push_exp(16'd4, 16'd1, OP_SUB);
    press(IC_CTOK);
    check("rp_valid", 32'(exec_valid), 32'd1);
    tick();
    give_result(16'd3);
    check("rp_disp_res", 32'(disp_value), 32'd3);

    // Reset while a request is pending; reset dominates cmd and res_valid
    do_reset();
    exec_ready = 1'b0;
    press(IC_NUM2);
    press(IC_OPAD);
    press(IC_NUM2);
    press(IC_CTOK);
    check("mr_valid_hi", 32'(exec_valid), 32'd1);
    Reset     = 1'b0;
    cmd       = IC_NUM5;
    res_valid = 1'b1;
    res_data  = 16'd99;
    tick();
    cmd       = IC_NONE;
    res_valid = 1'b0;
    Reset     = 1'b1;
    check("mr_valid_lo", 32'(exec_valid), 32'd0);
    check("mr_disp", 32'(disp_value), 32'd0);
    check("mr_state", 32'(dbg_state), 32'(S_A));
    check("mr_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("mr_valid_stays_lo", 32'(exec_valid), 32'd0);

    // Every expected request must have been transferred
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
